// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_pkg
//  Description : Shared types and widths for the memory bus initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    // Bus sequencing phases of one transfer
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

endpackage : mem_bus_pkg
`default_nettype wire

// File: rtl/mem_bus_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_master_if
//  Description : Request/response channel between the CPU/DMA sequencer
//                (master) and the memory bus initiator (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_master_if;
    import mem_bus_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );

endinterface : mem_bus_master_if
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wait_counter
//  Description : Down-counter that stretches the ACCESS phase. Loaded on the
//                edge entering ACCESS, done_o is high once it reaches zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;

    // Load the wait count, then count down and park at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign done_o = (count_q == '0);

endmodule : mem_wait_counter
`default_nettype wire

// File: rtl/mem_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_master
//  Description : Single-byte memory bus initiator. Sequences IDLE -> SETUP ->
//                ACCESS -> RECOVER, drives abus/outn/writen/mbus from
//                registered state and returns read data with a one-cycle
//                rsp_valid pulse.
//                Optional macro MEM_BUS_WAIT_EN stretches ACCESS by
//                WAIT_STATES cycles through mem_wait_counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_master_if.slave   req_if,
    output logic [ADDR_W-1:0] abus,
    output logic              outn,
    output logic              writen,
    inout  wire  [DATA_W-1:0] mbus
);

    state_t            state_q;
    state_t            state_d;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic w_req_ready;
    logic w_accept;
    logic w_access_done;
    logic w_capture;
    logic w_drive;
    logic w_rsp_valid;

    // A negative wait count has no meaning; reject it at elaboration
    if (WAIT_STATES < 0) begin : g_bad_wait_states
        $error("mem_bus_master: WAIT_STATES must be non-negative");
    end

`ifdef MEM_BUS_WAIT_EN
    localparam int C_CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    // SETUP always leads into ACCESS, so loading here arms the first ACCESS cycle
    logic w_cnt_load;
    assign w_cnt_load = (state_q == ST_SETUP);

    mem_wait_counter #(
        .WIDTH (C_CNT_W)
    ) u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_cnt_load),
        .load_val_i (C_CNT_W'(WAIT_STATES)),
        .done_o     (w_access_done)
    );
`else
    assign w_access_done = 1'b1;
`endif

    // Ready only in the two phases that may start a transfer, never in reset
    assign w_req_ready = !reset && ((state_q == ST_IDLE) || (state_q == ST_RECOVER));
    assign w_accept    = w_req_ready && req_if.req_valid;
    assign w_capture   = (state_q == ST_ACCESS) && !write_q && w_access_done;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; RECOVER chains straight into SETUP for back-to-back use
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (req_if.req_valid) state_d = ST_SETUP;
            ST_SETUP:   state_d = ST_ACCESS;
            ST_ACCESS:  if (w_access_done) state_d = ST_RECOVER;
            ST_RECOVER: state_d = req_if.req_valid ? ST_SETUP : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Strobe, bus-enable and response decode from registered state only
    always_comb begin
        outn        = 1'b1;
        writen      = 1'b1;
        w_drive     = 1'b0;
        w_rsp_valid = 1'b0;
        case (state_q)
            ST_SETUP: begin
                w_drive = write_q;
            end
            ST_ACCESS: begin
                w_drive = write_q;
                writen  = !write_q;
                outn    = write_q;
            end
            ST_RECOVER: begin
                w_drive     = write_q;
                w_rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Request latch and read-data capture; a reset edge suppresses the capture
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            if (w_accept) begin
                write_q <= req_if.req_write;
                addr_q  <= req_if.req_addr;
                wdata_q <= req_if.req_wdata;
            end
            if (w_capture) begin
                rsp_data_q <= mbus;
            end
        end
    end

    assign mbus             = w_drive ? wdata_q : 8'bz;
    assign abus             = addr_q;
    assign req_if.req_ready = w_req_ready;
    assign req_if.rsp_valid = w_rsp_valid;
    assign req_if.rsp_data  = rsp_data_q;

endmodule : mem_bus_master
`default_nettype wire
